// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// fields and every datapath mux/ALU select the controller drives.
package ctrl_pkg;

  // Controller states; the exception sequence is split into its two cycles.
  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_R_EXEC    = 4'd3,
    ST_R_WB      = 4'd4,
    ST_ADDI_EXEC = 4'd5,
    ST_ADDI_WB   = 4'd6,
    ST_MEM_ADDR  = 4'd7,
    ST_LW_READ   = 4'd8,
    ST_LW_WB     = 4'd9,
    ST_SW_WRITE  = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12,
    ST_EXC       = 4'd13,
    ST_EXC_VEC   = 4'd14
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;

  // ALU operations
  localparam logic [2:0] ALU_LOAD_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_CMP    = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Register file destination select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] REGDST_SP = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // Register file write-data select (stack init code is a top parameter)
  localparam logic [2:0] DSRC_ALUOUT = 3'b000;
  localparam logic [2:0] DSRC_MDR    = 3'b001;

  // Exception causes
  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_INVALID = 2'b01;
  localparam logic [1:0] EXC_OVF     = 2'b10;

  // True for the R-type functions this controller implements.
  function automatic logic is_rfunct_valid(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND);
  endfunction

  // ALU operation for an implemented R-type function.
  function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
    logic [2:0] op;
    case (f)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      default: op = ALU_LOAD_A;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter shared by instruction fetch and load reads. It counts up
// to MEM_WAIT, saturates there, and flags when the memory result is valid.
module mem_wait_counter #(
  parameter int CNT_W    = 3,
  parameter int MEM_WAIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MEM_WAIT);

  logic [CNT_W-1:0] r_count;

  // Count memory wait cycles; clear has priority and the count never passes MEM_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_done) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_done = (r_count == LP_LAST);

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle CPU control FSM: sequences fetch, decode and the ALU, load/store,
// branch, jump and exception paths, driving every datapath enable and mux.
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int         MEM_WAIT    = 3,
  parameter logic [2:0] SP_INIT_SEL = 3'b110,
  parameter int         CNT_W       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Overflow,
  input  logic       Negativo,
  input  logic       Zero,
  input  logic       EQ,
  input  logic       GT,
  input  logic       LT,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       pc_w,
  output logic       mem_w,
  output logic       ir_w,
  output logic       reg_w,
  output logic       reg_ab_w,
  output logic       aluOut_w,
  output logic       mdr_w,
  output logic       epc_w,
  output logic       hi_w,
  output logic       lo_w,
  output logic       alu_src_a,
  output logic       iord,
  output logic [1:0] alu_src_b,
  output logic [1:0] reg_dst,
  output logic [1:0] pc_src,
  output logic [2:0] data_src,
  output logic [2:0] alu_op,
  output logic [1:0] exc_cause,
  output logic       rst_out
);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_exc_cause;
  logic [1:0] w_exc_cause_nxt;
  logic       w_cnt_clear;
  logic       w_cnt_inc;
  logic       w_cnt_done;
  logic       w_unused;

  // The sign/compare flags other than EQ are not needed by this instruction set.
  assign w_unused = &{1'b0, Negativo, Zero, GT, LT};

  mem_wait_counter #(
    .CNT_W   (CNT_W),
    .MEM_WAIT(MEM_WAIT)
  ) u_wait_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .i_clear(w_cnt_clear),
    .i_inc  (w_cnt_inc),
    .o_done (w_cnt_done)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Exception cause is latched on entry to the exception sequence and cleared on return to fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exc_cause <= EXC_NONE;
    end else begin
      r_exc_cause <= w_exc_cause_nxt;
    end
  end

  // Next-state and output decode; reset low overrides everything so no write can slip through.
  always_comb begin
    w_next_state    = r_state;
    w_exc_cause_nxt = r_exc_cause;
    w_cnt_clear     = 1'b1;
    w_cnt_inc       = 1'b0;
    pc_w            = 1'b0;
    mem_w           = 1'b0;
    ir_w            = 1'b0;
    reg_w           = 1'b0;
    reg_ab_w        = 1'b0;
    aluOut_w        = 1'b0;
    mdr_w           = 1'b0;
    epc_w           = 1'b0;
    hi_w            = 1'b0;
    lo_w            = 1'b0;
    alu_src_a       = 1'b0;
    iord            = 1'b0;
    alu_src_b       = SRCB_B;
    reg_dst         = REGDST_RT;
    pc_src          = PCSRC_ALU;
    data_src        = DSRC_ALUOUT;
    alu_op          = ALU_LOAD_A;
    exc_cause       = r_exc_cause;
    rst_out         = 1'b0;

    case (r_state)
      ST_RESET: begin
        reg_dst      = REGDST_SP;
        data_src     = SP_INIT_SEL;
        reg_w        = 1'b1;
        w_next_state = ST_FETCH;
      end

      ST_FETCH: begin
        iord      = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (w_cnt_done) begin
          ir_w         = 1'b1;
          pc_src       = PCSRC_ALU;
          pc_w         = 1'b1;
          w_next_state = ST_DECODE;
        end else begin
          w_cnt_clear = 1'b0;
          w_cnt_inc   = 1'b1;
        end
      end

      ST_DECODE: begin
        reg_ab_w  = 1'b1;
        aluOut_w  = 1'b1;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (is_rfunct_valid(funct)) begin
              w_next_state = ST_R_EXEC;
            end else begin
              w_next_state    = ST_EXC;
              w_exc_cause_nxt = EXC_INVALID;
            end
          end
          OP_ADDI:      w_next_state = ST_ADDI_EXEC;
          OP_LW, OP_SW: w_next_state = ST_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next_state = ST_BRANCH;
          OP_J:         w_next_state = ST_JUMP;
          default: begin
            w_next_state    = ST_EXC;
            w_exc_cause_nxt = EXC_INVALID;
          end
        endcase
      end

      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_op    = funct_alu_op(funct);
        aluOut_w  = 1'b1;
        if (Overflow && (funct != FN_AND)) begin
          w_next_state    = ST_EXC;
          w_exc_cause_nxt = EXC_OVF;
        end else begin
          w_next_state = ST_R_WB;
        end
      end

      ST_R_WB: begin
        reg_dst      = REGDST_RD;
        data_src     = DSRC_ALUOUT;
        reg_w        = 1'b1;
        w_next_state = ST_FETCH;
      end

      ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        aluOut_w  = 1'b1;
        if (Overflow) begin
          w_next_state    = ST_EXC;
          w_exc_cause_nxt = EXC_OVF;
        end else begin
          w_next_state = ST_ADDI_WB;
        end
      end

      ST_ADDI_WB: begin
        reg_dst      = REGDST_RT;
        data_src     = DSRC_ALUOUT;
        reg_w        = 1'b1;
        w_next_state = ST_FETCH;
      end

      ST_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ADD;
        aluOut_w     = 1'b1;
        w_next_state = (opcode == OP_SW) ? ST_SW_WRITE : ST_LW_READ;
      end

      ST_LW_READ: begin
        iord = 1'b1;
        if (w_cnt_done) begin
          mdr_w        = 1'b1;
          w_next_state = ST_LW_WB;
        end else begin
          w_cnt_clear = 1'b0;
          w_cnt_inc   = 1'b1;
        end
      end

      ST_LW_WB: begin
        reg_dst      = REGDST_RT;
        data_src     = DSRC_MDR;
        reg_w        = 1'b1;
        w_next_state = ST_FETCH;
      end

      ST_SW_WRITE: begin
        iord         = 1'b1;
        mem_w        = 1'b1;
        w_next_state = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_B;
        alu_op       = ALU_CMP;
        pc_src       = PCSRC_ALUOUT;
        pc_w         = (opcode == OP_BNE) ? !EQ : EQ;
        w_next_state = ST_FETCH;
      end

      ST_JUMP: begin
        pc_src       = PCSRC_JUMP;
        pc_w         = 1'b1;
        w_next_state = ST_FETCH;
      end

      ST_EXC: begin
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_FOUR;
        alu_op       = ALU_SUB;
        epc_w        = 1'b1;
        w_next_state = ST_EXC_VEC;
      end

      ST_EXC_VEC: begin
        pc_src          = PCSRC_EXC;
        pc_w            = 1'b1;
        w_next_state    = ST_FETCH;
        w_exc_cause_nxt = EXC_NONE;
      end

      default: begin
        w_next_state    = ST_RESET;
        w_exc_cause_nxt = EXC_NONE;
      end
    endcase

    if (!reset) begin
      pc_w      = 1'b0;
      mem_w     = 1'b0;
      ir_w      = 1'b0;
      reg_w     = 1'b0;
      reg_ab_w  = 1'b0;
      aluOut_w  = 1'b0;
      mdr_w     = 1'b0;
      epc_w     = 1'b0;
      hi_w      = 1'b0;
      lo_w      = 1'b0;
      alu_src_a = 1'b0;
      iord      = 1'b0;
      alu_src_b = SRCB_B;
      reg_dst   = REGDST_RT;
      pc_src    = PCSRC_ALU;
      data_src  = DSRC_ALUOUT;
      alu_op    = ALU_LOAD_A;
      exc_cause = EXC_NONE;
      rst_out   = 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Testbench for multicycle_ctrl_unit: per-instruction cycle traces are built
// from the instruction-level behaviour and compared cycle by cycle.
module tb_multicycle_ctrl_unit;

  localparam int         MW     = 3;
  localparam logic [2:0] SP_SEL = 3'b110;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] JMP   = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;

  typedef struct packed {
    logic       pc_w, mem_w, ir_w, reg_w, reg_ab_w, aluOut_w, mdr_w, epc_w, hi_w, lo_w;
    logic       alu_src_a, iord;
    logic [1:0] alu_src_b, reg_dst, pc_src;
    logic [2:0] data_src, alu_op;
    logic [1:0] exc_cause;
    logic       rst_out;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Overflow = 1'b0, Negativo = 1'b0, Zero = 1'b0, EQ = 1'b0, GT = 1'b0, LT = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       pc_w, mem_w, ir_w, reg_w, reg_ab_w, aluOut_w, mdr_w, epc_w, hi_w, lo_w;
  logic       alu_src_a, iord, rst_out;
  logic [1:0] alu_src_b, reg_dst, pc_src, exc_cause;
  logic [2:0] data_src, alu_op;

  int   nCompared = 0;
  int   nMismatched = 0;
  cyc_t expQ[$];

  multicycle_ctrl_unit #(
    .MEM_WAIT   (MW),
    .SP_INIT_SEL(SP_SEL),
    .CNT_W      (3)
  ) dut (
    .clk(clk), .reset(reset),
    .Overflow(Overflow), .Negativo(Negativo), .Zero(Zero), .EQ(EQ), .GT(GT), .LT(LT),
    .opcode(opcode), .funct(funct),
    .pc_w(pc_w), .mem_w(mem_w), .ir_w(ir_w), .reg_w(reg_w), .reg_ab_w(reg_ab_w),
    .aluOut_w(aluOut_w), .mdr_w(mdr_w), .epc_w(epc_w), .hi_w(hi_w), .lo_w(lo_w),
    .alu_src_a(alu_src_a), .iord(iord), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .pc_src(pc_src), .data_src(data_src), .alu_op(alu_op), .exc_cause(exc_cause),
    .rst_out(rst_out)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends even if the stimulus stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic cyc_t observe();
    cyc_t c;
    c.pc_w = pc_w;           c.mem_w = mem_w;         c.ir_w = ir_w;
    c.reg_w = reg_w;         c.reg_ab_w = reg_ab_w;   c.aluOut_w = aluOut_w;
    c.mdr_w = mdr_w;         c.epc_w = epc_w;         c.hi_w = hi_w;
    c.lo_w = lo_w;           c.alu_src_a = alu_src_a; c.iord = iord;
    c.alu_src_b = alu_src_b; c.reg_dst = reg_dst;     c.pc_src = pc_src;
    c.data_src = data_src;   c.alu_op = alu_op;       c.exc_cause = exc_cause;
    c.rst_out = rst_out;
    return c;
  endfunction

  // Reference model: the full list of per-cycle outputs one instruction should produce.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic eq);
    cyc_t       c;
    logic [1:0] cause;
    logic       rvalid;
    expQ.delete();
    for (int i = 0; i <= MW; i++) begin
      c = '0; c.alu_src_b = 2'b01; c.alu_op = 3'b001;
      if (i == MW) begin c.ir_w = 1'b1; c.pc_w = 1'b1; end
      expQ.push_back(c);
    end
    c = '0; c.reg_ab_w = 1'b1; c.aluOut_w = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 3'b001;
    expQ.push_back(c);
    cause  = 2'b00;
    rvalid = (fn == F_ADD) || (fn == F_SUB) || (fn == F_AND);
    if (op == RTYPE && rvalid) begin
      c = '0; c.alu_src_a = 1'b1; c.aluOut_w = 1'b1;
      c.alu_op = (fn == F_ADD) ? 3'b001 : (fn == F_SUB) ? 3'b010 : 3'b011;
      expQ.push_back(c);
      if (ovf && fn != F_AND) cause = 2'b10;
      else begin c = '0; c.reg_dst = 2'b01; c.reg_w = 1'b1; expQ.push_back(c); end
    end else if (op == ADDI) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b001; c.aluOut_w = 1'b1;
      expQ.push_back(c);
      if (ovf) cause = 2'b10;
      else begin c = '0; c.reg_dst = 2'b00; c.reg_w = 1'b1; expQ.push_back(c); end
    end else if (op == LW || op == SW) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b001; c.aluOut_w = 1'b1;
      expQ.push_back(c);
      if (op == LW) begin
        for (int i = 0; i <= MW; i++) begin
          c = '0; c.iord = 1'b1; c.mdr_w = (i == MW);
          expQ.push_back(c);
        end
        c = '0; c.reg_dst = 2'b00; c.data_src = 3'b001; c.reg_w = 1'b1; expQ.push_back(c);
      end else begin
        c = '0; c.iord = 1'b1; c.mem_w = 1'b1; expQ.push_back(c);
      end
    end else if (op == BEQ || op == BNE) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b111; c.pc_src = 2'b01;
      c.pc_w = (op == BEQ) ? eq : ~eq;
      expQ.push_back(c);
    end else if (op == JMP) begin
      c = '0; c.pc_src = 2'b10; c.pc_w = 1'b1; expQ.push_back(c);
    end else begin
      cause = 2'b01;
    end
    if (cause != 2'b00) begin
      c = '0; c.alu_src_b = 2'b01; c.alu_op = 3'b010; c.epc_w = 1'b1; c.exc_cause = cause;
      expQ.push_back(c);
      c = '0; c.pc_src = 2'b11; c.pc_w = 1'b1; c.exc_cause = cause;
      expQ.push_back(c);
    end
  endtask

  // Put an instruction and its flags on the inputs; unused flags get random values.
  task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic eq);
    opcode = op; funct = fn; Overflow = ovf; EQ = eq;
    Negativo = 1'($urandom); Zero = 1'($urandom); GT = 1'($urandom); LT = 1'($urandom);
  endtask

  task automatic test_reset();
    cyc_t exp, obs;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    exp = '0; exp.rst_out = 1'b1;
    obs = observe(); nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL reset_state: got %h required %h", obs, exp);
    end
    reset = 1'b1; #1;
    exp = '0; exp.reg_dst = 2'b11; exp.data_src = SP_SEL; exp.reg_w = 1'b1;
    obs = observe(); nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL reset_release: got %h required %h", obs, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [5:0] fns[3] = '{F_ADD, F_SUB, F_AND};
    cyc_t obs;
    for (int k = 0; k < 3; k++) begin
      model_instr(RTYPE, fns[k], (k == 2), 1'b0);
      drive_instr(RTYPE, fns[k], (k == 2), 1'b0);
      foreach (expQ[i]) begin
        @(negedge clk); obs = observe(); nCompared++;
        if (obs !== expQ[i]) begin
          nMismatched++;
          $display("[TB] FAIL alu funct=%b cycle %0d: got %h required %h", fns[k], i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_overflow();
    logic [5:0] ops[3] = '{RTYPE, RTYPE, ADDI};
    logic [5:0] fns[3] = '{F_ADD, F_SUB, 6'b000000};
    cyc_t obs;
    for (int k = 0; k < 3; k++) begin
      model_instr(ops[k], fns[k], 1'b1, 1'b0);
      drive_instr(ops[k], fns[k], 1'b1, 1'b0);
      foreach (expQ[i]) begin
        @(negedge clk); obs = observe(); nCompared++;
        if (obs !== expQ[i]) begin
          nMismatched++;
          $display("[TB] FAIL overflow op=%b cycle %0d: got %h required %h", ops[k], i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_load_store();
    logic [5:0] ops[2] = '{LW, SW};
    cyc_t obs;
    for (int k = 0; k < 2; k++) begin
      model_instr(ops[k], 6'($urandom), 1'b1, 1'b0);
      drive_instr(ops[k], funct, 1'b1, 1'b0);
      foreach (expQ[i]) begin
        @(negedge clk); obs = observe(); nCompared++;
        if (obs !== expQ[i]) begin
          nMismatched++;
          $display("[TB] FAIL load_store op=%b cycle %0d: got %h required %h", ops[k], i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops[5] = '{BEQ, BEQ, BNE, BNE, JMP};
    logic       eqs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cyc_t obs;
    for (int k = 0; k < 5; k++) begin
      model_instr(ops[k], 6'b000000, 1'b0, eqs[k]);
      drive_instr(ops[k], 6'b000000, 1'b0, eqs[k]);
      foreach (expQ[i]) begin
        @(negedge clk); obs = observe(); nCompared++;
        if (obs !== expQ[i]) begin
          nMismatched++;
          $display("[TB] FAIL branch_jump op=%b eq=%b cycle %0d: got %h required %h",
                   ops[k], eqs[k], i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_invalid();
    logic [5:0] ops[2] = '{6'b111111, RTYPE};
    logic [5:0] fns[2] = '{6'b100000, 6'b000000};
    cyc_t obs;
    for (int k = 0; k < 2; k++) begin
      model_instr(ops[k], fns[k], 1'b0, 1'b0);
      drive_instr(ops[k], fns[k], 1'b0, 1'b0);
      foreach (expQ[i]) begin
        @(negedge clk); obs = observe(); nCompared++;
        if (obs !== expQ[i]) begin
          nMismatched++;
          $display("[TB] FAIL invalid op=%b funct=%b cycle %0d: got %h required %h",
                   ops[k], fns[k], i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    logic       ovf, eq;
    int         sel;
    cyc_t       obs;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 8);
      case (sel)
        0, 1:    op = RTYPE;
        2:       op = ADDI;
        3:       op = LW;
        4:       op = SW;
        5:       op = BEQ;
        6:       op = BNE;
        7:       op = JMP;
        default: op = 6'($urandom);
      endcase
      sel = $urandom_range(0, 3);
      fn  = (sel == 0) ? F_ADD : (sel == 1) ? F_SUB : (sel == 2) ? F_AND : 6'($urandom);
      ovf = 1'($urandom);
      eq  = 1'($urandom);
      model_instr(op, fn, ovf, eq);
      drive_instr(op, fn, ovf, eq);
      foreach (expQ[i]) begin
        @(negedge clk); obs = observe(); nCompared++;
        if (obs !== expQ[i]) begin
          nMismatched++;
          $display("[TB] FAIL random#%0d op=%b fn=%b ovf=%b eq=%b cycle %0d: got %h required %h",
                   n, op, fn, ovf, eq, i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_lw();
    cyc_t exp, obs;
    model_instr(LW, 6'b000000, 1'b0, 1'b0);
    drive_instr(LW, 6'b000000, 1'b0, 1'b0);
    for (int i = 0; i < MW + 4; i++) begin
      @(negedge clk); obs = observe(); nCompared++;
      if (obs !== expQ[i]) begin
        nMismatched++;
        $display("[TB] FAIL mid_lw_lead cycle %0d: got %h required %h", i, obs, expQ[i]);
      end
      @(posedge clk); #1;
    end
    #2 reset = 1'b0; #1;
    exp = '0; exp.rst_out = 1'b1;
    obs = observe(); nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL abort_async: got %h required %h", obs, exp);
    end
    @(posedge clk); #1;
    obs = observe(); nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL abort_held: got %h required %h", obs, exp);
    end
    @(negedge clk); reset = 1'b1; #1;
    exp = '0; exp.reg_dst = 2'b11; exp.data_src = SP_SEL; exp.reg_w = 1'b1;
    obs = observe(); nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL abort_restart: got %h required %h", obs, exp);
    end
    @(posedge clk); #1;
    model_instr(RTYPE, F_ADD, 1'b0, 1'b0);
    drive_instr(RTYPE, F_ADD, 1'b0, 1'b0);
    foreach (expQ[i]) begin
      @(negedge clk); obs = observe(); nCompared++;
      if (obs !== expQ[i]) begin
        nMismatched++;
        $display("[TB] FAIL post_abort_add cycle %0d: got %h required %h", i, obs, expQ[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_alu();
    test_overflow();
    test_load_store();
    test_branch_jump();
    test_invalid();
    test_back_to_back();
    test_reset_mid_lw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
